// File: rtl/aes_round_seq.sv
// AES round sequencer: accepts a block, issues NR+1 round commands to an external
// datapath and returns the final state. Optional round-wait timeout: AES_RND_TIMEOUT_EN.
module aes_round_seq #(
    parameter int unsigned DATA_W      = 128,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic              clk_i,
    input  logic              rst_n,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic [1:0]        keylen_i,
    output logic              rnd_start_o,
    output logic [3:0]        rnd_idx_o,
    output logic              rnd_zero_o,
    output logic              rnd_final_o,
    output logic [DATA_W-1:0] rnd_state_o,
    input  logic              rnd_done_i,
    input  logic [DATA_W-1:0] rnd_state_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_err_o,
    input  logic              abort_i,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_OUT   = 2'd3;

    if (TIMEOUT_CYC == 0) begin : g_bad_cfg
        $error("aes_round_seq: TIMEOUT_CYC must be at least 1");
    end

    logic [1:0]        state_q;
    logic [3:0]        idx_q;
    logic [3:0]        nr_q;
    logic [DATA_W-1:0] st_q;
    logic              err_q;
    logic              rdy_q;
    logic              rnd_active;

`ifdef AES_RND_TIMEOUT_EN
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] tmo_q;
`endif

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            nr_q    <= '0;
            st_q    <= '0;
            err_q   <= 1'b0;
            rdy_q   <= 1'b0;
`ifdef AES_RND_TIMEOUT_EN
            tmo_q   <= '0;
`endif
        end else begin
            // rdy_q holds in_ready_o low until the first edge after reset release
            rdy_q <= 1'b1;
            if (abort_i) begin
                state_q <= S_IDLE;
                err_q   <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (in_valid_i && rdy_q) begin
                            idx_q <= '0;
                            if (keylen_i == 2'b11) begin
                                st_q    <= '0;
                                err_q   <= 1'b1;
                                state_q <= S_OUT;
                            end else begin
                                st_q    <= in_data_i;
                                err_q   <= 1'b0;
                                state_q <= S_ISSUE;
                                case (keylen_i)
                                    2'b01:   nr_q <= 4'd12;
                                    2'b10:   nr_q <= 4'd14;
                                    default: nr_q <= 4'd10;
                                endcase
                            end
                        end
                    end
                    S_ISSUE: begin
                        state_q <= S_WAIT;
`ifdef AES_RND_TIMEOUT_EN
                        tmo_q   <= '0;
`endif
                    end
                    S_WAIT: begin
                        if (rnd_done_i) begin
                            st_q <= rnd_state_i;
                            if (idx_q == nr_q) begin
                                state_q <= S_OUT;
                            end else begin
                                idx_q   <= idx_q + 4'd1;
                                state_q <= S_ISSUE;
                            end
                        end
`ifdef AES_RND_TIMEOUT_EN
                        else if (tmo_q == CNT_W'(TIMEOUT_CYC - 1)) begin
                            st_q    <= '0;
                            err_q   <= 1'b1;
                            state_q <= S_OUT;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
`endif
                    end
                    S_OUT: begin
                        if (out_ready_i) begin
                            err_q   <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    // Round command fields are held from ISSUE through WAIT; zero elsewhere
    assign rnd_active  = (state_q == S_ISSUE) || (state_q == S_WAIT);
    assign in_ready_o  = (state_q == S_IDLE) && rdy_q;
    assign rnd_start_o = (state_q == S_ISSUE) && !abort_i;
    assign rnd_idx_o   = rnd_active ? idx_q : '0;
    assign rnd_zero_o  = rnd_active && (idx_q == 4'd0);
    assign rnd_final_o = rnd_active && (idx_q == nr_q);
    assign rnd_state_o = rnd_active ? st_q : '0;
    assign out_valid_o = (state_q == S_OUT) && !abort_i;
    assign out_data_o  = out_valid_o ? st_q : '0;
    assign out_err_o   = out_valid_o && err_q;
    assign busy_o      = (state_q != S_IDLE);

endmodule
